// File: rtl/fft_sdf_bf2.sv
`default_nettype none
// ============================================================================
//  Module      : fft_sdf_bf2
//  Description : Radix-2 single-path delay-feedback DIF butterfly stage.
//                Streams one packed complex sample {re,im} per accepted cycle.
//                Frames are 2*DEPTH samples long. The first half of each frame
//                is parked in the delay line. The second half emits sums and
//                pushes differences back into the delay line. Those
//                differences leave, with their twiddle index, while the next
//                frame's first half is pushed in.
//                Optional macro BF_SCALE_EN: sum/diff are halved with an
//                arithmetic floor shift instead of being saturated.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_sdf_bf2 #(
    parameter int WIDTH      = 24,
    parameter int DEPTH      = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic [WIDTH-1:0]      out_data,
    output logic [LOG2_DEPTH-1:0] out_tw_idx,
    output logic                  out_tw_en
);

    localparam int                c_HALF = WIDTH / 2;
    localparam logic [LOG2_DEPTH:0] c_LAST = (LOG2_DEPTH + 1)'(2 * DEPTH - 1);
    localparam logic [LOG2_DEPTH:0] c_ONE  = (LOG2_DEPTH + 1)'(1);

    // Sample counter within the frame and "a full frame of differences is held" flag
    logic [LOG2_DEPTH:0]   r_cnt;
    logic                  r_primed;
    logic [WIDTH-1:0]      r_dly [DEPTH];

    logic [LOG2_DEPTH:0]   w_idx;
    logic [LOG2_DEPTH-1:0] w_k;
    logic                  w_phase;
    logic                  w_resync;
    logic                  w_primed_eff;
    logic [WIDTH-1:0]      w_head;
    logic [c_HALF-1:0]     w_d_re, w_d_im, w_x_re, w_x_im;
    logic [c_HALF:0]       w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic [WIDTH-1:0]      w_sum, w_diff;

    logic                  w_nxt_valid;
    logic                  w_nxt_sof;
    logic [WIDTH-1:0]      w_nxt_data;
    logic [LOG2_DEPTH-1:0] w_nxt_tw_idx;
    logic                  w_nxt_tw_en;

    // Brings an H+1-bit intermediate back to H bits: halve (floor) or saturate
    function automatic logic [c_HALF-1:0] f_fit(input logic [c_HALF:0] v);
`ifdef BF_SCALE_EN
        return v[c_HALF:1];
`else
        if (v[c_HALF] != v[c_HALF-1]) begin
            return v[c_HALF] ? {1'b1, {(c_HALF-1){1'b0}}} : {1'b0, {(c_HALF-1){1'b1}}};
        end
        return v[c_HALF-1:0];
`endif
    endfunction

    // A start-of-frame marker forces the current sample to index 0
    assign w_idx        = (in_valid && in_sof) ? '0 : r_cnt;
    assign w_k          = w_idx[LOG2_DEPTH-1:0];
    assign w_phase      = w_idx[LOG2_DEPTH];
    assign w_resync     = in_valid && in_sof && (r_cnt != '0);
    // A resync invalidates the held differences for this very sample too
    assign w_primed_eff = r_primed && !w_resync;

    assign w_head = r_dly[DEPTH-1];
    assign w_d_re = w_head[WIDTH-1:c_HALF];
    assign w_d_im = w_head[c_HALF-1:0];
    assign w_x_re = in_data[WIDTH-1:c_HALF];
    assign w_x_im = in_data[c_HALF-1:0];

    // Sign-extended one bit so the raw result never wraps
    assign w_sum_re = {w_d_re[c_HALF-1], w_d_re} + {w_x_re[c_HALF-1], w_x_re};
    assign w_sum_im = {w_d_im[c_HALF-1], w_d_im} + {w_x_im[c_HALF-1], w_x_im};
    assign w_dif_re = {w_d_re[c_HALF-1], w_d_re} - {w_x_re[c_HALF-1], w_x_re};
    assign w_dif_im = {w_d_im[c_HALF-1], w_d_im} - {w_x_im[c_HALF-1], w_x_im};

    assign w_sum  = {f_fit(w_sum_re), f_fit(w_sum_im)};
    assign w_diff = {f_fit(w_dif_re), f_fit(w_dif_im)};

    // Frame position and primed tracking; both move only on accepted samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
        end else if (in_valid) begin
            r_cnt <= w_idx + c_ONE;
            if (w_resync) begin
                r_primed <= 1'b0;
            end else if (w_idx == c_LAST) begin
                r_primed <= 1'b1;
            end
        end
    end

    // Delay line: first half parks raw input, second half parks differences
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_dly[0] <= w_phase ? w_diff : in_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Next output word; every field is zero whenever nothing is emitted
    always_comb begin
        w_nxt_valid  = 1'b0;
        w_nxt_sof    = 1'b0;
        w_nxt_data   = '0;
        w_nxt_tw_idx = '0;
        w_nxt_tw_en  = 1'b0;
        if (in_valid) begin
            if (w_phase) begin
                w_nxt_valid = 1'b1;
                w_nxt_sof   = (w_k == '0);
                w_nxt_data  = w_sum;
            end else if (w_primed_eff) begin
                w_nxt_valid  = 1'b1;
                w_nxt_data   = w_head;
                w_nxt_tw_idx = w_k;
                w_nxt_tw_en  = 1'b1;
            end
        end
    end

    // Output register: single cycle of latency from accept to result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_data   <= '0;
            out_tw_idx <= '0;
            out_tw_en  <= 1'b0;
        end else begin
            out_valid  <= w_nxt_valid;
            out_sof    <= w_nxt_sof;
            out_data   <= w_nxt_data;
            out_tw_idx <= w_nxt_tw_idx;
            out_tw_en  <= w_nxt_tw_en;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_sdf_bf2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_sdf_bf2
//  Description : Directed self-checking bench for fft_sdf_bf2 (WIDTH=24,
//                DEPTH=4). Expected values follow BF_SCALE_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_sdf_bf2;

    localparam int c_W = 24;
    localparam int c_D = 4;
    localparam int c_L = 2;
    localparam int c_E = c_W + c_L + 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_sof = 1'b0;
    logic [c_W-1:0] in_data = '0;
    logic           out_valid;
    logic           out_sof;
    logic [c_W-1:0] out_data;
    logic [c_L-1:0] out_tw_idx;
    logic           out_tw_en;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int orphan   = 0;
    logic last_acc = 1'b0;
    logic [c_E-1:0] cap [$];
    logic [c_E-1:0] exp_q [$];

    fft_sdf_bf2 #(.WIDTH(c_W), .DEPTH(c_D), .LOG2_DEPTH(c_L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_data   (out_data),
        .out_tw_idx (out_tw_idx),
        .out_tw_en  (out_tw_en)
    );

    always #5 clk = ~clk;

    // Remember whether the last edge accepted a sample
    always @(posedge clk) last_acc <= in_valid;

    // Capture every emitted word away from the active edge
    always @(negedge clk) begin
        if (out_valid) begin
            cap.push_back({out_sof, out_tw_en, out_tw_idx, out_data});
            if (!last_acc) orphan++;
        end
    end

    function automatic logic [c_W-1:0] cpx(input int re, input int im);
        logic [11:0] r;
        logic [11:0] i;
        r = re[11:0];
        i = im[11:0];
        return {r, i};
    endfunction

    function automatic logic [c_E-1:0] ent(input logic sof, input logic en,
                                           input int idx, input int re, input int im);
        logic [c_L-1:0] k;
        k = idx[c_L-1:0];
        return {sof, en, k, cpx(re, im)};
    endfunction

    task automatic send(input logic sof, input logic [c_W-1:0] d);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        cap.delete();
    endtask

    task automatic send_ramp_frame(input logic gaps);
        for (int n = 0; n < 2*c_D; n++) begin
            send(n == 0, cpx(n, 0));
            if (gaps) idle(1);
        end
    endtask

    // Two ramp frames: sums of frame 1, diffs out during frame 2, sums of frame 2
    task automatic build_ramp_exp();
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                for (int k = 0; k < c_D; k++)
`ifdef BF_SCALE_EN
                    exp_q.push_back(ent(1'b0, 1'b1, k, -2, 0));
`else
                    exp_q.push_back(ent(1'b0, 1'b1, k, -4, 0));
`endif
            end
            for (int j = 0; j < c_D; j++)
`ifdef BF_SCALE_EN
                exp_q.push_back(ent(j == 0, 1'b0, 0, 2 + j, 0));
`else
                exp_q.push_back(ent(j == 0, 1'b0, 0, 4 + 2*j, 0));
`endif
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_sof   = 1'($urandom_range(0, 1));
            in_data  = c_W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid got %b want 0", out_valid); end else pass_cnt++;
        if (out_sof !== 1'b0) begin fail_cnt++; $display("FAIL reset_sof got %b want 0", out_sof); end else pass_cnt++;
        if (out_tw_en !== 1'b0) begin fail_cnt++; $display("FAIL reset_tw_en got %b want 0", out_tw_en); end else pass_cnt++;
        if (out_data !== '0) begin fail_cnt++; $display("FAIL reset_data got %h want 0", out_data); end else pass_cnt++;
        if (out_tw_idx !== '0) begin fail_cnt++; $display("FAIL reset_tw_idx got %h want 0", out_tw_idx); end else pass_cnt++;
        rst_n = 1'b1;
        cap.delete();
    endtask

    task automatic test_ramp();
        apply_reset();
        build_ramp_exp();
        send_ramp_frame(1'b0);
        send_ramp_frame(1'b0);
        idle(2);
        if (cap.size() !== exp_q.size()) begin fail_cnt++; $display("FAIL ramp_count got %0d want %0d", cap.size(), exp_q.size()); end else pass_cnt++;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j >= cap.size() || cap[j] !== exp_q[j]) begin
                fail_cnt++;
                $display("FAIL ramp_word[%0d] got %h want %h", j, (j < cap.size()) ? cap[j] : 'x, exp_q[j]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        logic [c_W-1:0] a [4];
        logic [c_W-1:0] b [4];
        apply_reset();
        a[0] = cpx(2047, 100);   b[0] = cpx(2047, 2047);
        a[1] = cpx(-2048, -2048); b[1] = cpx(2047, 2047);
        a[2] = cpx(-1, 0);       b[2] = cpx(0, 0);
        a[3] = cpx(5, -7);       b[3] = cpx(3, -7);
        exp_q.delete();
`ifdef BF_SCALE_EN
        exp_q.push_back(ent(1'b1, 1'b0, 0, 2047, 1073));
        exp_q.push_back(ent(1'b0, 1'b0, 0, -1, -1));
        exp_q.push_back(ent(1'b0, 1'b0, 0, -1, 0));
        exp_q.push_back(ent(1'b0, 1'b0, 0, 4, -7));
        exp_q.push_back(ent(1'b0, 1'b1, 0, 0, -974));
        exp_q.push_back(ent(1'b0, 1'b1, 1, -2048, -2048));
        exp_q.push_back(ent(1'b0, 1'b1, 2, -1, 0));
        exp_q.push_back(ent(1'b0, 1'b1, 3, 1, 0));
`else
        exp_q.push_back(ent(1'b1, 1'b0, 0, 2047, 2047));
        exp_q.push_back(ent(1'b0, 1'b0, 0, -1, -1));
        exp_q.push_back(ent(1'b0, 1'b0, 0, -1, 0));
        exp_q.push_back(ent(1'b0, 1'b0, 0, 8, -14));
        exp_q.push_back(ent(1'b0, 1'b1, 0, 0, -1947));
        exp_q.push_back(ent(1'b0, 1'b1, 1, -2048, -2048));
        exp_q.push_back(ent(1'b0, 1'b1, 2, -1, 0));
        exp_q.push_back(ent(1'b0, 1'b1, 3, 2, 0));
`endif
        for (int k = 0; k < c_D; k++) exp_q.push_back(ent(k == 0, 1'b0, 0, 0, 0));
        for (int n = 0; n < c_D; n++) send(n == 0, a[n]);
        for (int n = 0; n < c_D; n++) send(1'b0, b[n]);
        for (int n = 0; n < 2*c_D; n++) send(n == 0, '0);
        idle(2);
        if (cap.size() !== exp_q.size()) begin fail_cnt++; $display("FAIL sat_count got %0d want %0d", cap.size(), exp_q.size()); end else pass_cnt++;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j >= cap.size() || cap[j] !== exp_q[j]) begin
                fail_cnt++;
                $display("FAIL sat_word[%0d] got %h want %h", j, (j < cap.size()) ? cap[j] : 'x, exp_q[j]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_gaps();
        apply_reset();
        build_ramp_exp();
        orphan = 0;
        send_ramp_frame(1'b1);
        send_ramp_frame(1'b1);
        idle(2);
        if (orphan !== 0) begin fail_cnt++; $display("FAIL gap_latency got %0d unaccepted outputs want 0", orphan); end else pass_cnt++;
        if (cap.size() !== exp_q.size()) begin fail_cnt++; $display("FAIL gap_count got %0d want %0d", cap.size(), exp_q.size()); end else pass_cnt++;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j >= cap.size() || cap[j] !== exp_q[j]) begin
                fail_cnt++;
                $display("FAIL gap_word[%0d] got %h want %h", j, (j < cap.size()) ? cap[j] : 'x, exp_q[j]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_resync_reset();
        apply_reset();
        send_ramp_frame(1'b0);
        for (int n = 0; n < 5; n++) send(n == 0, cpx(100 + n, 7));
        idle(1);
        cap.delete();
        send(1'b1, cpx(9, 9));
        for (int n = 1; n < c_D; n++) send(1'b0, cpx(9, 9));
        idle(1);
        if (cap.size() !== 0) begin fail_cnt++; $display("FAIL resync_stale got %0d words want 0", cap.size()); end else pass_cnt++;
        rst_n = 1'b0;
        in_valid = 1'b1; in_data = cpx(33, 44);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL resync_rst_valid got %b want 0", out_valid); end else pass_cnt++;
        if (out_data !== '0) begin fail_cnt++; $display("FAIL resync_rst_data got %h want 0", out_data); end else pass_cnt++;
        rst_n = 1'b1;
        idle(1);
        cap.delete();
        build_ramp_exp();
        send_ramp_frame(1'b0);
        send_ramp_frame(1'b0);
        idle(2);
        if (cap.size() !== exp_q.size()) begin fail_cnt++; $display("FAIL resync_count got %0d want %0d", cap.size(), exp_q.size()); end else pass_cnt++;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j >= cap.size() || cap[j] !== exp_q[j]) begin
                fail_cnt++;
                $display("FAIL resync_word[%0d] got %h want %h", j, (j < cap.size()) ? cap[j] : 'x, exp_q[j]);
            end else pass_cnt++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_ramp();
        test_saturation();
        test_gaps();
        test_resync_reset();
        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire
